ah_grant_burst_mux_8: RTL and testbench

//  Downstream consumer of the 8-requester round-robin arbiter. Latches the arbiter's
//  one-hot grant, locks onto the granted source and forwards its burst to a single

---
 rtl/ah_grant_burst_mux_8.sv | 102 ++++++++++
 tb/tb_ah_grant_burst_mux_8.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ah_grant_burst_mux_8.sv
// Grant-locked burst mux: latches a one-hot grant, forwards the owner's burst through a
// one-entry output register, and pulses done once the final beat has drained.
module ah_grant_burst_mux_8 #(
  parameter int unsigned N         = 8,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         gnt,
  input  logic [N-1:0]         src_valid,
  input  logic [N*DW-1:0]      src_data,
  input  logic [N-1:0]         src_last,
  output logic [N-1:0]         src_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [$clog2(N)-1:0] owner,
  output logic                 done,
  output logic                 err_multihot
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] beat_cnt;
  logic [OW-1:0] gnt_idx;
  logic          gnt_any, gnt_multi, lock;
  logic          slot_free, accept, cap_hit, beat_last, drain_hs;

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt[i]) gnt_idx = OW'(i);
    end
  end

  assign gnt_any   = |gnt;
  assign gnt_multi = |(gnt & (gnt - N'(1)));
  assign lock      = (state == IDLE) && gnt_any && !gnt_multi;

  // Output slot can take a beat when empty or being drained this same cycle.
  assign slot_free = ~out_valid | out_ready;
  assign accept    = (state == XFER) && src_valid[owner] && slot_free;
  assign cap_hit   = (beat_cnt == CW'(MAX_BEATS - 1));
  assign beat_last = src_last[owner] | cap_hit;
  assign drain_hs  = (state == DRAIN) && out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (lock) state_nx = XFER;
      XFER:    if (accept && beat_last) state_nx = DRAIN;
      DRAIN:   if (drain_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    src_ready = '0;
    if (state == XFER) src_ready[owner] = slot_free;
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner        <= '0;
      beat_cnt     <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      done         <= 1'b0;
      err_multihot <= 1'b0;
    end else begin
      done         <= drain_hs;
      err_multihot <= (state == IDLE) && gnt_multi;
      if (lock) begin
        owner    <= gnt_idx;
        beat_cnt <= '0;
      end
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= src_data[owner*DW +: DW];
        out_last  <= beat_last;
        beat_cnt  <= beat_cnt + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ah_grant_burst_mux_8.sv
// Scoreboard bench for ah_grant_burst_mux_8: sender tasks queue expected beats,
// a forked monitor pops and compares on every output handshake.
module tb_ah_grant_burst_mux_8;

  localparam int N    = 8;
  localparam int DW   = 32;
  localparam int MAXB = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    gnt;
  logic [N-1:0]    src_valid, src_last, src_ready;
  logic [N*DW-1:0] src_data;
  logic            out_valid, out_last, out_ready, busy, done, err_multihot;
  logic [DW-1:0]   out_data;
  logic [2:0]      owner;

  logic            sv[N];
  logic            sl[N];
  logic [DW-1:0]   sd[N];

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t sb[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      src_valid[i]          = sv[i];
      src_last[i]           = sl[i];
      src_data[i*DW +: DW]  = sd[i];
    end
  end

  ah_grant_burst_mux_8 #(.N(N), .DW(DW), .MAX_BEATS(MAXB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gnt          (gnt),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_last     (src_last),
    .src_ready    (src_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .busy         (busy),
    .owner        (owner),
    .done         (done),
    .err_multihot (err_multihot)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic  exp_done = 1'b0;
    beat_t b;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        exp_done = 1'b0;
        continue;
      end
      chk("done", done, exp_done);
      exp_done = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got data %0h with nothing expected", out_data);
        end else begin
          b = sb.pop_front();
          chk("out_data", out_data, b.d);
          chk("out_last", out_last, b.l);
          exp_done = b.l;
        end
      end
    end
  endtask

  task automatic send_burst(input int src, input int n, input logic [DW-1:0] base,
                            input int last_idx, output int cycles);
    int    i = 0;
    beat_t b;
    cycles = 0;
    @(negedge clk);
    while (i < n) begin
      sv[src] = 1'b1;
      sd[src] = base + DW'(i);
      sl[src] = (i == last_idx);
      #1;
      if (src_ready[src]) begin
        b.d = sd[src];
        b.l = (i == last_idx) || (i == MAXB - 1);
        sb.push_back(b);
        i++;
      end
      @(negedge clk);
      cycles++;
      if (cycles > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout src=%0d: got %0d beats expected %0d", src, i, n);
        break;
      end
    end
    sv[src] = 1'b0;
    sl[src] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_idle"}, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic lock_on(input logic [N-1:0] g);
    @(negedge clk);
    gnt = g;
    @(negedge clk);
    gnt = '0;
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    gnt       = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      sv[i] = 1'b0;
      sl[i] = 1'b0;
      sd[i] = '0;
    end
    fork
      monitor();
      begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1);
      end
    join_none

    #12;
    chk("rst_src_ready", src_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_multihot, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // multi-hot grant: error pulse, no lock
    @(negedge clk);
    gnt = 8'h81;
    @(negedge clk);
    gnt = '0;
    #1;
    chk("mh_err", err_multihot, 1);
    chk("mh_busy", busy, 0);
    chk("mh_src_ready", src_ready, 0);
    @(negedge clk);
    #1;
    chk("mh_err_clear", err_multihot, 0);
    chk("mh_busy2", busy, 0);

    // basic 3-beat burst from source 2
    lock_on(8'h04);
    #1;
    chk("b1_busy", busy, 1);
    chk("b1_owner", owner, 2);
    send_burst(2, 3, 32'h0000_00A0, 2, cyc);
    chk("b1_cycles", cyc, 3);
    wait_idle("b1");
    chk("b1_owner_hold", owner, 2);

    // downstream stall mid-burst from source 3
    lock_on(8'h08);
    fork
      send_burst(3, 6, 32'h0000_0300, 5, cyc);
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) begin
          #3;
          chk("stall_src_ready", src_ready[3], 0);
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, sb[0].d);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    wait_idle("b2");

    // grant change and foreign valid during a source-0 burst
    lock_on(8'h01);
    fork
      send_burst(0, 6, 32'h0000_0400, 5, cyc);
      begin
        @(negedge clk);
        gnt   = 8'h10;
        sv[4] = 1'b1;
        sd[4] = 32'hDEAD_0004;
        repeat (3) begin
          #3;
          chk("b4_src_ready4", src_ready[4], 0);
          chk("b4_owner", owner, 0);
          @(negedge clk);
        end
        gnt   = '0;
        sv[4] = 1'b0;
      end
    join
    wait_idle("b4");
    chk("b4_owner_end", owner, 0);

    // source 5 never asserts last: beat 16 is forced last, beat 17 refused
    lock_on(8'h20);
    send_burst(5, 16, 32'h0000_0500, -1, cyc);
    chk("b5_cycles", cyc, 16);
    sv[5] = 1'b1;
    sd[5] = 32'h0000_0510;
    repeat (4) begin
      #1;
      chk("b5_beat17_ready", src_ready[5], 0);
      @(negedge clk);
    end
    sv[5] = 1'b0;
    wait_idle("b5");

    // asynchronous reset while a beat sits in the output register
    lock_on(8'h02);
    out_ready = 1'b0;
    sv[1] = 1'b1;
    sd[1] = 32'h0000_0600;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("r6_valid_pre", out_valid, 1);
    chk("r6_busy_pre", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r6_out_valid", out_valid, 0);
    chk("r6_out_data", out_data, 0);
    chk("r6_busy", busy, 0);
    chk("r6_src_ready", src_ready, 0);
    chk("r6_owner", owner, 0);
    @(negedge clk);
    sv[1]     = 1'b0;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("r6_busy_after", busy, 0);
    chk("r6_done_after", done, 0);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
